// File: rtl/serial_bit_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_bit_tx                                                  |
// | Brief   : valid/ready parallel-to-serial shifter with optional idle gap. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module serial_bit_tx #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int BCW = $clog2(WIDTH);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] C_LAST_CNT = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] C_GAP_LOAD = GCW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_cnt_nxt;
    logic [GCW-1:0]   r_gap_cnt;
    logic [GCW-1:0]   w_gap_cnt_nxt;
    logic             w_out_bit;
    logic             w_ready;

    assign w_out_bit = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
    assign w_shifted = LSB_FIRST ? {1'b0, r_shreg[WIDTH-1:1]} : {r_shreg[WIDTH-2:0], 1'b0};

    // Ready is forced low while reset is held so nothing is offered to a block in reset.
    assign s_ready = rst_n & w_ready;
    assign busy    = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_ready       = 1'b0;
        sout          = IDLE_BIT;
        sout_valid    = 1'b0;
        word_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (s_valid) begin
                    w_state_nxt   = ST_SHIFT;
                    w_shreg_nxt   = s_data;
                    w_bit_cnt_nxt = C_LAST_CNT;
                end
            end
            ST_SHIFT: begin
                sout        = w_out_bit;
                sout_valid  = 1'b1;
                w_shreg_nxt = w_shifted;
                if (r_bit_cnt == '0) begin
                    word_done = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = C_GAP_LOAD;
                    end else begin
                        // Last-bit cycle doubles as a load slot for a gapless stream.
                        w_ready = 1'b1;
                        if (s_valid) begin
                            w_shreg_nxt   = s_data;
                            w_bit_cnt_nxt = C_LAST_CNT;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - BCW'(1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GCW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
